rob_commit_unit: RTL and testbench

- Retire-side engine of the out-of-order core.
- Tracks ROB head/tail tags and allocation count.
- Each cycle, selects up to MAX_COMMIT ready head entries in program order. Drives regfile write ports plus the commit stream (commit, num_deq, flush.front_tag) consumed by the commit checker.
- Resolves branch/jump mispredicts at retirement by emitting a one-cycle flush with the redirect PC.

---
 rtl/rv32i_types.sv | 60 ++++++
 rtl/rob_commit_unit_select.sv | 46 ++++
 rtl/rob_commit_unit.sv | 102 ++++++++++
 tb/tb_rob_commit_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the retire path: ROB entry, flush bundle, commit port.
// Also holds the ROB geometry and the modulo tag adder.
package rv32i_types;

    localparam int ROB_SIZE   = 15;
    localparam int XLEN       = 32;
    localparam int MAX_COMMIT = 2;
    localparam int TAG_W      = $clog2(ROB_SIZE);
    localparam int CNT_W      = $clog2(ROB_SIZE + 1);

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [4:0]  rd;
    } pc_info_t;

    typedef struct packed {
        logic            rdy;
        logic [XLEN-1:0] data;
        pc_info_t        pc_info;
    } sal2_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] front_tag;
        logic [XLEN-1:0]  pc;
    } flush_t;

    typedef struct packed {
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } commit_port_t;

    // Wraps with a compare so non-power-of-two sizes work; n <= size.
    function automatic logic [TAG_W-1:0] tag_add(
        input logic [TAG_W-1:0] tag,
        input logic [TAG_W:0]   n,
        input int unsigned      size
    );
        logic [TAG_W:0] s;
        s = {1'b0, tag} + n;
        if (s >= (TAG_W + 1)'(size))
            s = s - (TAG_W + 1)'(size);
        return s[TAG_W-1:0];
    endfunction

endpackage

// File: rtl/rob_commit_unit_select.sv
// commit_select: in-order retire chain over the ROB head slots.
// in: front_tag, count, rdy, mispredict; out: retire, num_deq, mp_hit, mp_tag.
module commit_select
    import rv32i_types::*;
#(
    parameter int size = ROB_SIZE
) (
    input  logic [TAG_W-1:0]      front_tag,
    input  logic [CNT_W-1:0]      count,
    input  logic [size-1:0]       rdy,
    input  logic [size-1:0]       mispredict,
    output logic [MAX_COMMIT-1:0] retire,
    output logic [2:0]            num_deq,
    output logic                  mp_hit,
    output logic [TAG_W-1:0]      mp_tag
);

    logic             alive;
    logic [TAG_W-1:0] t;

    // A slot retires only if every older slot retired; a mispredicted
    // entry retires itself but closes the chain behind it.
    always_comb begin
        retire  = '0;
        num_deq = 3'd0;
        mp_hit  = 1'b0;
        mp_tag  = '0;
        alive   = 1'b1;
        t       = '0;
        for (int k = 0; k < MAX_COMMIT; k++) begin
            t = tag_add(front_tag, (TAG_W + 1)'(k), size);
            if (alive && (CNT_W'(k) < count) && rdy[t]) begin
                retire[k] = 1'b1;
                num_deq   = num_deq + 3'd1;
                if (mispredict[t]) begin
                    mp_hit = 1'b1;
                    mp_tag = t;
                    alive  = 1'b0;
                end
            end else begin
                alive = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: ROB head/tail/count, regfile write ports, mispredict flush.
// in: clk, rst(async low), alloc, rdest, mispredict, target_pc; out: tags, status, rf_*, flush.
module rob_commit_unit
    import rv32i_types::*;
#(
    parameter int size  = ROB_SIZE,
    parameter int width = XLEN
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alloc,
    input  sal2_t                            rdest [size],
    input  logic [size-1:0]                  mispredict,
    input  logic [width-1:0]                 target_pc [size],
    output logic [TAG_W-1:0]                 front_tag,
    output logic [TAG_W-1:0]                 rear_tag,
    output logic                             full,
    output logic                             empty,
    output logic                             commit,
    output logic [2:0]                       num_deq,
    output logic [MAX_COMMIT-1:0]            rf_we,
    output logic [MAX_COMMIT-1:0][4:0]       rf_rd,
    output logic [MAX_COMMIT-1:0][width-1:0] rf_data,
    output flush_t                           flush
);

    logic [CNT_W-1:0]      count;
    logic [size-1:0]       rdy;
    logic [MAX_COMMIT-1:0] retire;
    logic                  mp_hit;
    logic [TAG_W-1:0]      mp_tag;
    logic [TAG_W-1:0]      pt;
    logic [TAG_W-1:0]      redirect_tag;
    logic                  alloc_acc;
    commit_port_t          port [MAX_COMMIT];

    always_comb begin
        rdy = '0;
        for (int i = 0; i < size; i++)
            rdy[i] = rdest[i].rdy;
    end

    commit_select #(.size(size)) u_sel (
        .front_tag  (front_tag),
        .count      (count),
        .rdy        (rdy),
        .mispredict (mispredict),
        .retire     (retire),
        .num_deq    (num_deq),
        .mp_hit     (mp_hit),
        .mp_tag     (mp_tag)
    );

    assign full   = (count == CNT_W'(size));
    assign empty  = (count == '0);
    assign commit = |num_deq;

    always_comb begin
        pt = '0;
        for (int k = 0; k < MAX_COMMIT; k++) begin
            pt = tag_add(front_tag, (TAG_W + 1)'(k), size);
            port[k].we = retire[k]
                && (rdest[pt].pc_info.rd != 5'd0)
                && (rdest[pt].pc_info.opcode != op_br)
                && (rdest[pt].pc_info.opcode != op_store);
            port[k].rd   = rdest[pt].pc_info.rd;
            port[k].data = rdest[pt].data;
            rf_we[k]     = port[k].we;
            rf_rd[k]     = port[k].rd;
            rf_data[k]   = port[k].data;
        end
    end

    // front_tag is the pre-update head so the checker can index from it.
    assign flush.valid     = mp_hit;
    assign flush.front_tag = front_tag;
    assign flush.pc        = target_pc[mp_tag];

    assign redirect_tag = tag_add(mp_tag, (TAG_W + 1)'(1), size);
    // Allocation into a full ROB is dropped even if a slot frees this cycle.
    assign alloc_acc    = alloc && !full && !flush.valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front_tag <= '0;
            rear_tag  <= '0;
            count     <= '0;
        end else if (flush.valid) begin
            front_tag <= redirect_tag;
            rear_tag  <= redirect_tag;
            count     <= '0;
        end else begin
            front_tag <= tag_add(front_tag, (TAG_W + 1)'(num_deq), size);
            rear_tag  <= tag_add(rear_tag, (TAG_W + 1)'(alloc_acc), size);
            count     <= count + CNT_W'(alloc_acc) - CNT_W'(num_deq);
        end
    end

    a_alloc_full: assert property (@(posedge clk) disable iff (!rst)
        !(alloc && full && (num_deq == 3'd0)));

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed scenarios then random traffic.
// Expectations come from a queue-of-tags model of the ROB.
module tb_rob_commit_unit;
    import rv32i_types::*;

    localparam int N = ROB_SIZE;

    logic                           clk = 1'b0;
    logic                           rst = 1'b0;
    logic                           alloc = 1'b0;
    sal2_t                          rob [N];
    logic [N-1:0]                   mp = '0;
    logic [XLEN-1:0]                tpc [N];
    logic [TAG_W-1:0]               front_tag;
    logic [TAG_W-1:0]               rear_tag;
    logic                           full;
    logic                           empty;
    logic                           commit;
    logic [2:0]                     num_deq;
    logic [MAX_COMMIT-1:0]          rf_we;
    logic [MAX_COMMIT-1:0][4:0]     rf_rd;
    logic [MAX_COMMIT-1:0][XLEN-1:0] rf_data;
    flush_t                         flush;

    rob_commit_unit dut (
        .clk        (clk),
        .rst        (rst),
        .alloc      (alloc),
        .rdest      (rob),
        .mispredict (mp),
        .target_pc  (tpc),
        .front_tag  (front_tag),
        .rear_tag   (rear_tag),
        .full       (full),
        .empty      (empty),
        .commit     (commit),
        .num_deq    (num_deq),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int q[$];
    int m_front = 0;
    int m_rear = 0;
    int e_n;
    bit e_mp;
    int e_mpt;
    int new_tag;
    rv32i_opcode ops [6] = '{op_reg, op_imm, op_load, op_br, op_store, op_jal};

    task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic set_e(int t, bit r, rv32i_opcode op, logic [4:0] rd,
                         logic [XLEN-1:0] d);
        rob[t].rdy = r;
        rob[t].data = d;
        rob[t].pc_info.opcode = op;
        rob[t].pc_info.rd = rd;
    endtask

    task automatic clear();
        for (int i = 0; i < N; i++) begin
            set_e(i, 1'b0, op_reg, 5'd0, '0);
            tpc[i] = $urandom;
        end
        mp = '0;
    endtask

    // Oldest-first walk of the live entries.
    task automatic eval();
        e_n = 0;
        e_mp = 0;
        e_mpt = 0;
        for (int k = 0; k < MAX_COMMIT; k++) begin
            int t;
            if (k >= q.size()) break;
            t = q[k];
            if (!rob[t].rdy) break;
            e_n++;
            if (mp[t]) begin
                e_mp = 1;
                e_mpt = t;
                break;
            end
        end
    endtask

    task automatic check_all(string s);
        #1;
        eval();
        chk({s, ".front"}, front_tag, m_front);
        chk({s, ".rear"}, rear_tag, m_rear);
        chk({s, ".full"}, full, q.size() == N);
        chk({s, ".empty"}, empty, q.size() == 0);
        chk({s, ".num_deq"}, num_deq, e_n);
        chk({s, ".commit"}, commit, e_n != 0);
        chk({s, ".fl_valid"}, flush.valid, e_mp);
        chk({s, ".fl_front"}, flush.front_tag, m_front);
        if (e_mp) chk({s, ".fl_pc"}, flush.pc, tpc[e_mpt]);
        for (int k = 0; k < MAX_COMMIT; k++) begin
            bit we;
            we = 0;
            if (k < e_n) begin
                int t;
                t = q[k];
                we = rob[t].pc_info.rd != 0
                    && rob[t].pc_info.opcode != op_br
                    && rob[t].pc_info.opcode != op_store;
                chk({s, ".rf_rd"}, rf_rd[k], rob[t].pc_info.rd);
                chk({s, ".rf_data"}, rf_data[k], rob[t].data);
            end
            chk({s, ".rf_we"}, rf_we[k], we);
        end
    endtask

    task automatic tick();
        bit ok;
        eval();
        ok = alloc && q.size() < N && !e_mp;
        new_tag = -1;
        @(posedge clk);
        #1;
        if (e_mp) begin
            m_front = (e_mpt + 1) % N;
            m_rear = m_front;
            q.delete();
        end else begin
            repeat (e_n) void'(q.pop_front());
            m_front = (m_front + e_n) % N;
            if (ok) begin
                q.push_back(m_rear);
                new_tag = m_rear;
                m_rear = (m_rear + 1) % N;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst.front", front_tag, 0);
        chk("rst.rear", rear_tag, 0);
        chk("rst.full", full, 0);
        chk("rst.empty", empty, 1);
        chk("rst.commit", commit, 0);
        chk("rst.num_deq", num_deq, 0);
        chk("rst.rf_we", rf_we, 0);
        chk("rst.fl_valid", flush.valid, 0);
        q.delete();
        m_front = 0;
        m_rear = 0;
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clear();
        @(posedge clk);
        #1;
        do_reset();

        // three allocs, two retire then one (x0 destination)
        alloc = 1'b1;
        repeat (3) begin
            check_all("t1a");
            tick();
        end
        alloc = 1'b0;
        set_e(0, 1'b1, op_reg, 5'd5, 32'h1111);
        set_e(1, 1'b1, op_reg, 5'd6, 32'h2222);
        set_e(2, 1'b1, op_reg, 5'd0, 32'h3333);
        check_all("t1c1");
        chk("t1.n1", num_deq, 2);
        chk("t1.we1", rf_we, 2'b11);
        tick();
        check_all("t1c2");
        chk("t1.n2", num_deq, 1);
        chk("t1.we2", rf_we, 2'b00);
        tick();
        check_all("t1end");
        chk("t1.front", front_tag, 3);
        chk("t1.empty", empty, 1);

        // head not ready blocks the younger ready entry
        set_e(3, 1'b0, op_reg, 5'd1, 32'hA);
        set_e(4, 1'b1, op_imm, 5'd7, 32'hB);
        alloc = 1'b1;
        repeat (2) begin
            check_all("t2a");
            tick();
        end
        alloc = 1'b0;
        check_all("t2blk");
        chk("t2.n0", num_deq, 0);
        chk("t2.c0", commit, 0);
        tick();
        rob[3].rdy = 1'b1;
        check_all("t2go");
        chk("t2.n2", num_deq, 2);
        tick();
        check_all("t2end");

        // fill to full; extra alloc dropped while one retires
        do_reset();
        clear();
        alloc = 1'b1;
        repeat (15) begin
            check_all("t3a");
            tick();
        end
        check_all("t3full");
        chk("t3.full", full, 1);
        chk("t3.rear", rear_tag, 0);
        rob[0].rdy = 1'b1;
        check_all("t3drop");
        tick();
        alloc = 1'b0;
        check_all("t3after");
        chk("t3.full0", full, 0);
        chk("t3.rear0", rear_tag, 0);

        // head wrap from 14
        do_reset();
        clear();
        for (int i = 0; i < 14; i++) begin
            set_e(i, 1'b1, op_reg, 5'(i + 1), $urandom);
            alloc = 1'b1;
            check_all("t4a");
            tick();
        end
        alloc = 1'b0;
        check_all("t4b");
        tick();
        check_all("t4c");
        chk("t4.front14", front_tag, 14);
        set_e(14, 1'b0, op_reg, 5'd9, 32'h14);
        set_e(0, 1'b0, op_load, 5'd10, 32'h15);
        alloc = 1'b1;
        repeat (2) begin
            check_all("t4d");
            tick();
        end
        alloc = 1'b0;
        rob[14].rdy = 1'b1;
        rob[0].rdy = 1'b1;
        check_all("t4wrap");
        chk("t4.flfront", flush.front_tag, 14);
        chk("t4.n2", num_deq, 2);
        tick();
        check_all("t4end");
        chk("t4.front1", front_tag, 1);

        // mispredicted branch at head, younger alloc dropped
        do_reset();
        clear();
        alloc = 1'b1;
        repeat (2) begin
            check_all("t5a");
            tick();
        end
        set_e(0, 1'b1, op_br, 5'd0, 32'h0);
        mp[0] = 1'b1;
        tpc[0] = 32'h80;
        set_e(1, 1'b1, op_reg, 5'd9, 32'h99);
        check_all("t5mp");
        chk("t5.flv", flush.valid, 1);
        chk("t5.flpc", flush.pc, 32'h80);
        chk("t5.n1", num_deq, 1);
        tick();
        alloc = 1'b0;
        check_all("t5end");
        chk("t5.front", front_tag, 1);
        chk("t5.rear", rear_tag, 1);
        chk("t5.empty", empty, 1);
        mp = '0;

        // reset in the middle of a retiring, flushing cycle
        do_reset();
        clear();
        alloc = 1'b1;
        repeat (7) begin
            check_all("t6a");
            tick();
        end
        alloc = 1'b0;
        set_e(0, 1'b1, op_reg, 5'd3, 32'h33);
        set_e(1, 1'b1, op_jal, 5'd4, 32'h44);
        mp[1] = 1'b1;
        check_all("t6pre");
        do_reset();
        mp = '0;
        check_all("t6post");
        tick();
        check_all("t6end");

        // random traffic
        do_reset();
        clear();
        repeat (400) begin
            foreach (q[i]) begin
                int t;
                t = q[i];
                if (!rob[t].rdy && $urandom_range(0, 2) == 0) begin
                    rob[t].rdy = 1'b1;
                    if ($urandom_range(0, 9) == 0) begin
                        mp[t] = 1'b1;
                        tpc[t] = $urandom;
                    end
                end
            end
            eval();
            alloc = ($urandom_range(0, 3) != 0) && (q.size() < N || e_n > 0);
            check_all("rnd");
            tick();
            if (new_tag >= 0) begin
                set_e(new_tag, 1'b0, ops[$urandom_range(0, 5)],
                      5'($urandom_range(0, 31)), $urandom);
                mp[new_tag] = 1'b0;
            end
        end
        alloc = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
